// File: rtl/booth_mul_pkg.sv
// Shared types for the radix-2 Booth multiplier: FSM states and the
// per-step recoding operation derived from {Q[0], q_m1}.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;

  // Radix-2 Booth recoding: 01 -> add M, 10 -> subtract M, 00/11 -> nothing.
  function automatic logic [1:0] booth_op(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/addsub_cla.sv
// W-bit two's-complement adder/subtractor with carry-lookahead carry chain.
// m=0: s = a + b, m=1: s = a - b (computed as a + ~b + 1).
// c is the carry out of the MSB, v the signed overflow flag.
module addsub_cla #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] s,
  output logic         c,
  output logic         v
);

  logic [W-1:0] bx;
  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W:0]   cy;

  // Generate/propagate terms and the lookahead carry recurrence.
  always_comb begin
    bx    = b ^ {W{m}};
    gen   = a & bx;
    prop  = a ^ bx;
    cy    = '0;
    cy[0] = m;
    for (int i = 0; i < W; i++) begin
      cy[i+1] = gen[i] | (prop[i] & cy[i]);
    end
  end

  assign s = prop ^ cy[W-1:0];
  assign c = cy[W];
  assign v = cy[W] ^ cy[W-1];

endmodule

// File: rtl/booth_mul.sv
// Sequential radix-2 Booth multiplier, one recoded bit per clock.
//
//   state | meaning
//   ------+--------------------------------------------------
//   IDLE  | in_ready=1, waiting for an operand handshake
//   RUN   | one Booth add/sub + arithmetic shift per cycle
//   DONE  | out_valid=1, p={ACC,Q} held until out_ready
//
// Optional macro BOOTH_MUL_UNSIGNED_EN adds port is_unsigned and widens the
// datapath to W+1 bits (operands zero- or sign-extended), running W+1 steps.
//
// ACC is only as wide as the operands, so ACC +/- M can overflow (e.g. when
// M is the most-negative value). The shift therefore inserts the true sign of
// the untruncated sum rather than the MSB of the truncated one, which keeps
// every product exact without widening the accumulator.
module booth_mul
  import booth_mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
`ifdef BOOTH_MUL_UNSIGNED_EN
  input  logic           is_unsigned,
`endif
  output logic [2*W-1:0] p
);

`ifdef BOOTH_MUL_UNSIGNED_EN
  localparam int DW = W + 1;
`else
  localparam int DW = W;
`endif
  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t state, state_nxt;

  logic [DW-1:0] acc;
  logic [DW-1:0] q;
  logic [DW-1:0] m;
  logic          q_m1;
  logic [CW-1:0] cnt;

  logic [DW-1:0] a_ext;
  logic [DW-1:0] b_ext;
  logic [1:0]    op;
  logic [DW-1:0] sum;
  logic [DW-1:0] acc_step;
  logic          sum_sign;
  logic          eff_sign;
  logic          ovf;
  logic          add_c_unused;
  logic          add_v_unused;

`ifdef BOOTH_MUL_UNSIGNED_EN
  assign a_ext = {~is_unsigned & a[W-1], a};
  assign b_ext = {~is_unsigned & b[W-1], b};
`else
  assign a_ext = a;
  assign b_ext = b;
`endif

  assign op = booth_op(q[0], q_m1);

  addsub_cla #(.W(DW)) u_addsub (
    .a (acc),
    .b (m),
    .m (op == SUB),
    .s (sum),
    .c (add_c_unused),
    .v (add_v_unused)
  );

  // Pick the Booth step result and recover the sign of the full-precision sum.
  always_comb begin
    eff_sign = m[DW-1] ^ (op == SUB);
    ovf      = (acc[DW-1] == eff_sign) && (sum[DW-1] != acc[DW-1]);
    acc_step = acc;
    sum_sign = acc[DW-1];
    if (op != NOP) begin
      acc_step = sum;
      sum_sign = ovf ? acc[DW-1] : sum[DW-1];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, one add/sub + arithmetic shift per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      q    <= '0;
      m    <= '0;
      q_m1 <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m    <= a_ext;
            q    <= b_ext;
            acc  <= '0;
            q_m1 <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          acc  <= {sum_sign, acc_step[DW-1:1]};
          q    <= {acc_step[0], q[DW-1:1]};
          q_m1 <= q[0];
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BOOTH_MUL_UNSIGNED_EN
  assign p = out_valid ? {acc[W-2:0], q} : '0;
`else
  assign p = out_valid ? {acc, q} : '0;
`endif

endmodule

// File: doc/booth_mul.md
BOOTH_MUL -- requirements
Module: booth_mul

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits (W >= 2).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 Port in_valid, input, 1 bit: operands a/b are presented.
REQ-005 Port in_ready, output, 1 bit: the block accepts operands.
REQ-006 Port a, input, W bits: multiplicand, two's complement.
REQ-007 Port b, input, W bits: multiplier, two's complement.
REQ-008 Port out_valid, output, 1 bit: product p is valid.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts p.
REQ-010 Port p, output, 2W bits: the product.

Function
REQ-011 The block SHALL implement radix-2 Booth multiplication with a three-state machine: IDLE, RUN, DONE.
REQ-012 IDLE SHALL assert in_ready=1; an input handshake (in_valid & in_ready) SHALL load M=a, Q=b, ACC=0, q_m1=0 and step counter=0, then go to RUN.
REQ-013 Each RUN cycle SHALL examine {Q[0],q_m1}: 01 -> ACC=ACC+M; 10 -> ACC=ACC-M; 00/11 -> ACC unchanged.
REQ-014 In the same cycle, {ACC,Q,q_m1} SHALL then arithmetic-shift right by 1, with the ACC sign bit replicated.
REQ-015 Each RUN cycle SHALL increment the counter; after the W-th step the state SHALL become DONE.
REQ-016 Latency SHALL be exactly W+1 edges from the input-handshake edge to the first cycle with out_valid=1.
REQ-017 In DONE, out_valid=1 and p={ACC,Q}; p SHALL hold stable until out_ready=1.
REQ-018 An output handshake SHALL return the state to IDLE, with in_ready=1 in the following cycle; there is no same-cycle accept in DONE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and SHALL NOT corrupt state.
REQ-020 Add/subtract SHALL use W-bit two's-complement arithmetic; carry-out and overflow SHALL be discarded.
REQ-021 The most-negative operands (-2^(W-1) on either or both inputs) SHALL produce the exact 2W-bit product.
REQ-022 p SHALL read 0 whenever out_valid=0.

Reset
REQ-023 On rst_n=0, the state SHALL become IDLE immediately, with in_ready=1, out_valid=0, p=0, and ACC/Q/M/q_m1/counter all cleared.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the operation; no out_valid pulse SHALL follow.
REQ-025 After rst_n deasserts, the first input handshake SHALL be accepted on the first rising edge.

Configuration
REQ-026 Macro BOOTH_MUL_UNSIGNED_EN, when defined, SHALL add port is_unsigned (input, 1 bit, sampled at the input handshake).
REQ-027 With BOOTH_MUL_UNSIGNED_EN and is_unsigned=1, operands SHALL be zero-extended to W+1 bits and W+1 steps run; p SHALL be the low 2W bits; latency SHALL be W+2.
REQ-028 With BOOTH_MUL_UNSIGNED_EN and is_unsigned=0, behaviour SHALL be as signed (sign-extended to W+1 bits); latency SHALL be W+2.
REQ-029 Without BOOTH_MUL_UNSIGNED_EN, there SHALL be no is_unsigned port, the datapath SHALL be W bits, operation SHALL be signed only, and latency SHALL be W+1.

Structure
REQ-030 Package booth_mul_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the Booth op encoding constants (NOP/ADD/SUB).
REQ-031 The add/subtract SHALL instantiate existing module addsub_cla with W (or W+1) width, using M=0 for add and M=1 for subtract; its C and V outputs SHALL be left unused.
REQ-032 The counter SHALL be $clog2(W+2) bits wide.

Verification
REQ-033 W=8 signed: a=3, b=-5 -> p=0xFFF1, out_valid first seen exactly 9 edges after accept.
REQ-034 W=8: a=-128, b=-128 -> p=0x4000; a=127, b=-128 -> p=0xC080; a=0, b=0x55 -> p=0.
REQ-035 W=8: a=-7, b=6 with out_ready held 0 for 5 cycles -> p=0xFFD6 stable, out_valid=1 throughout, in_ready=0; after out_ready=1, in_ready=1 the next cycle.
REQ-036 W=8: rst_n pulled low on RUN step 4 -> out_valid=0 and p=0 immediately; a new op 2*3 -> p=0x0006.
REQ-037 W=8 with BOOTH_MUL_UNSIGNED_EN: is_unsigned=1, a=255, b=255 -> p=0xFE01 after 10 edges; is_unsigned=0, same operands -> p=0x0001.
REQ-038 W=8: back-to-back randomized ops against a reference model -> all products match, with no accepts while busy.
